// File: rtl/rf_port_arbiter.sv
// rf_port_arbiter
//   Shares one single-port 4x32 register file between NREQ requesters.
//   Round-robin arbitration with an optional lock so a single requester can
//   run an atomic read-modify-write. A lock that is held too long is released
//   by force, and the sticky lock_timeout flag is set.
//   Accesses are issued combinationally in the grant cycle. Read data comes
//   back one cycle later on the rvalid bit of the requester that issued it.
//
// Ports
//   clk, rst_n          system clock (rising edge), async active-low reset
//   req/req_we/req_lock per-requester valid, write(1)/read(0), keep-lock
//   req_addr/req_wdata  per-requester address (2b) and write data (32b), packed
//   gnt                 one-hot accept, access issued in the same cycle
//   rvalid/rdata        one-hot read-return pulse and its data
//   lock_timeout(_clr)  sticky forced-release flag and its clear
//   rf_wen/rf_ren/rf_addr/rf_data_in  RF command lines
//   rf_data_out         registered RF read data
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_ARB    | round-robin among all requesters, starting at rr_ptr
// ST_LOCKED | only owner_q may be granted; lock_cnt_q counts its grants

module rf_port_arbiter #(
    parameter int NREQ     = 2,
    parameter int LOCK_MAX = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_we,
    input  logic [NREQ-1:0]      req_lock,
    input  logic [NREQ*2-1:0]    req_addr,
    input  logic [NREQ*32-1:0]   req_wdata,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      rvalid,
    output logic [31:0]          rdata,
    output logic                 lock_timeout,
    input  logic                 lock_timeout_clr,
    output logic                 rf_wen,
    output logic                 rf_ren,
    output logic [1:0]           rf_addr,
    output logic [31:0]          rf_data_in,
    input  logic [31:0]          rf_data_out
);

    localparam int IW = (NREQ > 2) ? 2 : 1;

    typedef enum logic {
        ST_ARB,
        ST_LOCKED
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [7:0]      lock_cnt_q, lock_cnt_d;
    logic            rd_pend_q, rd_pend_d;
    logic [IW-1:0]   rd_tag_q, rd_tag_d;
    logic            lock_timeout_q, lock_timeout_d;

    logic            arb_hit;
    logic [IW-1:0]   arb_idx;
    logic            grant_vld;
    logic [IW-1:0]   grant_idx;
    logic            grant_we;
    logic            timeout;

    function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
        ptr_inc = (p == IW'(NREQ - 1)) ? '0 : p + IW'(1);
    endfunction

    // Rotating priority search starting at rr_ptr_q.
    always_comb begin
        arb_hit = 1'b0;
        arb_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            int            j;
            logic [IW-1:0] cand;
            j = int'(rr_ptr_q) + i;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            cand = IW'(j);
            if (!arb_hit && req[cand]) begin
                arb_hit = 1'b1;
                arb_idx = cand;
            end
        end
    end

    // Grant decision. Gated by rst_n so the command lines sit at their reset
    // values for the whole time reset is asserted, even with requests pending.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        timeout   = 1'b0;
        if (rst_n) begin
            case (state_q)
                ST_ARB: begin
                    if (arb_hit) begin
                        grant_vld = 1'b1;
                        grant_idx = arb_idx;
                    end
                end
                ST_LOCKED: begin
                    if (lock_cnt_q == 8'(LOCK_MAX)) begin
                        timeout = 1'b1;
                    end else if (req[owner_q]) begin
                        grant_vld = 1'b1;
                        grant_idx = owner_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        gnt        = '0;
        grant_we   = 1'b0;
        rf_wen     = 1'b0;
        rf_ren     = 1'b0;
        rf_addr    = '0;
        rf_data_in = '0;
        if (grant_vld) begin
            for (int i = 0; i < NREQ; i++) begin
                if (grant_idx == IW'(i)) begin
                    gnt[i]     = 1'b1;
                    grant_we   = req_we[i];
                    rf_wen     = req_we[i];
                    rf_ren     = !req_we[i];
                    rf_addr    = req_addr[i*2 +: 2];
                    rf_data_in = req_we[i] ? req_wdata[i*32 +: 32] : '0;
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        lock_cnt_d = lock_cnt_q;
        rd_pend_d  = grant_vld && !grant_we;
        rd_tag_d   = (grant_vld && !grant_we) ? grant_idx : rd_tag_q;

        // A set and a clear in the same cycle: the set wins.
        if (timeout) begin
            lock_timeout_d = 1'b1;
        end else if (lock_timeout_clr) begin
            lock_timeout_d = 1'b0;
        end else begin
            lock_timeout_d = lock_timeout_q;
        end

        case (state_q)
            ST_ARB: begin
                if (grant_vld) begin
                    rr_ptr_d = ptr_inc(grant_idx);
                    if (req_lock[grant_idx]) begin
                        state_d    = ST_LOCKED;
                        owner_d    = grant_idx;
                        lock_cnt_d = 8'd1;
                    end
                end
            end
            ST_LOCKED: begin
                if (timeout) begin
                    // Hand priority to the next requester after the owner.
                    state_d    = ST_ARB;
                    rr_ptr_d   = ptr_inc(owner_q);
                    lock_cnt_d = '0;
                end else if (grant_vld) begin
                    if (req_lock[owner_q]) begin
                        lock_cnt_d = lock_cnt_q + 8'd1;
                    end else begin
                        state_d    = ST_ARB;
                        lock_cnt_d = '0;
                    end
                end else if (!req_lock[owner_q]) begin
                    state_d    = ST_ARB;
                    lock_cnt_d = '0;
                end
            end
            default: begin
                state_d = ST_ARB;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_ARB;
            rr_ptr_q       <= '0;
            owner_q        <= '0;
            lock_cnt_q     <= '0;
            rd_pend_q      <= 1'b0;
            rd_tag_q       <= '0;
            lock_timeout_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            owner_q        <= owner_d;
            lock_cnt_q     <= lock_cnt_d;
            rd_pend_q      <= rd_pend_d;
            rd_tag_q       <= rd_tag_d;
            lock_timeout_q <= lock_timeout_d;
        end
    end

    // Read return: the RF registers its output at the grant edge, so
    // rf_data_out already holds the data in the cycle after the grant.
    always_comb begin
        rvalid = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (rd_pend_q && (rd_tag_q == IW'(i))) begin
                rvalid[i] = 1'b1;
            end
        end
    end

    assign rdata        = rd_pend_q ? rf_data_out : '0;
    assign lock_timeout = lock_timeout_q;

endmodule

// File: tb/tb_rf_port_arbiter.sv
module tb_rf_port_arbiter;

    localparam int NREQ     = 2;
    localparam int LOCK_MAX = 8;

    localparam logic [31:0] M0 = 32'h0000_A000;
    localparam logic [31:0] M1 = 32'h1111_B001;
    localparam logic [31:0] M2 = 32'h2222_C002;
    localparam logic [31:0] M3 = 32'h3333_D003;
    localparam logic [31:0] DB = 32'hDEAD_BEEF;
    localparam logic [31:0] FD = 32'h0BAD_F00D;
    localparam logic [31:0] FE = 32'h0BAD_F00E;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req, req_we, req_lock;
    logic [NREQ*2-1:0]    req_addr;
    logic [NREQ*32-1:0]   req_wdata;
    logic [NREQ-1:0]      gnt, rvalid;
    logic [31:0]          rdata;
    logic                 lock_timeout, lock_timeout_clr;
    logic                 rf_wen, rf_ren;
    logic [1:0]           rf_addr;
    logic [31:0]          rf_data_in, rf_data_out;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    typedef struct {
        int          cyc;
        int          idx;
        logic        we;
        logic [1:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t gq[$];
    exp_t rq[$];

    rf_port_arbiter #(.NREQ(NREQ), .LOCK_MAX(LOCK_MAX)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req              (req),
        .req_we           (req_we),
        .req_lock         (req_lock),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .gnt              (gnt),
        .rvalid           (rvalid),
        .rdata            (rdata),
        .lock_timeout     (lock_timeout),
        .lock_timeout_clr (lock_timeout_clr),
        .rf_wen           (rf_wen),
        .rf_ren           (rf_ren),
        .rf_addr          (rf_addr),
        .rf_data_in       (rf_data_in),
        .rf_data_out      (rf_data_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Register file environment model: single port, registered read data.
    logic [31:0] mem [4] = '{M0, M1, M2, M3};
    logic [31:0] rf_q = '0;
    assign rf_data_out = rf_q;
    always @(posedge clk) begin
        if (rf_wen) mem[rf_addr] <= rf_data_in;
        if (rf_ren) rf_q <= mem[rf_addr];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        req       = '0;
        req_we    = '0;
        req_lock  = '0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    task automatic set_req(input int i, input logic v, input logic we, input logic lk,
                           input logic [1:0] a, input logic [31:0] d);
        req[i]               = v;
        req_we[i]            = we;
        req_lock[i]          = lk;
        req_addr[i*2 +: 2]   = a;
        req_wdata[i*32 +: 32] = d;
    endtask

    // Expected grant in the current cycle; reads also expect a return next cycle.
    task automatic exp_gnt(input int idx, input logic we, input logic [1:0] a,
                           input logic [31:0] d, input bit ret);
        exp_t e;
        e.cyc  = cyc;
        e.idx  = idx;
        e.we   = we;
        e.addr = a;
        e.data = we ? d : 32'h0;
        gq.push_back(e);
        if (!we && ret) begin
            e.cyc  = cyc + 1;
            e.data = d;
            rq.push_back(e);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_gnt"},   64'(gnt), 64'h0);
        chk({tag, "_rvalid"}, 64'(rvalid), 64'h0);
        chk({tag, "_rdata"}, 64'(rdata), 64'h0);
        chk({tag, "_lto"},   64'(lock_timeout), 64'h0);
        chk({tag, "_rfcmd"}, {28'h0, rf_wen, rf_ren, rf_addr, rf_data_in}, 64'h0);
    endtask

    // Monitor: pops and compares whenever the DUT presents a grant or read return.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (gnt != '0) begin
                if (gq.size() == 0) begin
                    chk("gnt_unexpected", 64'(gnt), 64'h0);
                end else begin
                    exp_t e;
                    e = gq.pop_front();
                    chk("gnt_cycle", 64'(cyc), 64'(e.cyc));
                    chk("gnt_vec", 64'(gnt), 64'(1) << e.idx);
                    chk("rf_wen", 64'(rf_wen), 64'(e.we));
                    chk("rf_ren", 64'(rf_ren), 64'(!e.we));
                    chk("rf_addr", 64'(rf_addr), 64'(e.addr));
                    chk("rf_data_in", 64'(rf_data_in), 64'(e.data));
                end
            end else begin
                chk("idle_cmd", {28'h0, rf_wen, rf_ren, rf_addr, rf_data_in}, 64'h0);
            end
            if (rvalid != '0) begin
                if (rq.size() == 0) begin
                    chk("rvalid_unexpected", 64'(rvalid), 64'h0);
                end else begin
                    exp_t e;
                    e = rq.pop_front();
                    chk("rvalid_cycle", 64'(cyc), 64'(e.cyc));
                    chk("rvalid_tag", 64'(rvalid), 64'(1) << e.idx);
                    chk("rdata", 64'(rdata), 64'(e.data));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        clear_all();
        lock_timeout_clr = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("rst");
        rst_n = 1'b1;
        tick();

        // Single read by requester 0.
        set_req(0, 1, 0, 0, 2'd3, 32'h0);
        exp_gnt(0, 0, 2'd3, M3, 1);
        tick();
        clear_all();
        tick();

        // Write then read by requester 1 (rr_ptr = 1).
        set_req(1, 1, 1, 0, 2'd3, DB);
        exp_gnt(1, 1, 2'd3, DB, 1);
        tick();
        set_req(1, 1, 0, 0, 2'd3, 32'h0);
        exp_gnt(1, 0, 2'd3, DB, 1);
        tick();
        clear_all();
        tick();

        // Contention, rr_ptr = 0: grants alternate 0,1,0,1 then 1 alone writes.
        set_req(0, 1, 0, 0, 2'd0, 32'h0);
        set_req(1, 1, 0, 0, 2'd1, 32'h0);
        exp_gnt(0, 0, 2'd0, M0, 1);
        tick();
        set_req(0, 1, 0, 0, 2'd2, 32'h0);
        exp_gnt(1, 0, 2'd1, M1, 1);
        tick();
        set_req(1, 1, 0, 0, 2'd3, 32'h0);
        exp_gnt(0, 0, 2'd2, M2, 1);
        tick();
        exp_gnt(1, 0, 2'd3, DB, 1);
        tick();
        set_req(0, 0, 0, 0, 2'd0, 32'h0);
        set_req(1, 1, 1, 0, 2'd2, FD);
        exp_gnt(1, 1, 2'd2, FD, 1);
        tick();
        clear_all();
        tick();

        // Locked read-modify-write by 0 while 1 waits exactly two cycles.
        set_req(0, 1, 0, 1, 2'd2, 32'h0);
        set_req(1, 1, 0, 0, 2'd2, 32'h0);
        exp_gnt(0, 0, 2'd2, FD, 1);
        tick();
        set_req(0, 1, 1, 0, 2'd2, FE);
        exp_gnt(0, 1, 2'd2, FE, 1);
        tick();
        set_req(0, 0, 0, 0, 2'd0, 32'h0);
        exp_gnt(1, 0, 2'd2, FE, 1);
        tick();
        clear_all();
        tick();

        // Lock timeout: 8 grants to 0, one release cycle, then 1 wins.
        set_req(0, 1, 0, 1, 2'd0, 32'h0);
        set_req(1, 1, 0, 0, 2'd1, 32'h0);
        for (int k = 0; k < LOCK_MAX; k++) begin
            exp_gnt(0, 0, 2'd0, M0, 1);
            chk("lto_during_lock", 64'(lock_timeout), 64'h0);
            tick();
        end
        lock_timeout_clr = 1'b1;
        chk("lto_before_release", 64'(lock_timeout), 64'h0);
        tick();
        exp_gnt(1, 0, 2'd1, M1, 1);
        chk("lto_set_wins", 64'(lock_timeout), 64'h1);
        tick();
        clear_all();
        lock_timeout_clr = 1'b0;
        chk("lto_cleared", 64'(lock_timeout), 64'h0);
        tick();

        // Owner holds lock while idle, then drops it without a request.
        set_req(0, 1, 0, 1, 2'd3, 32'h0);
        exp_gnt(0, 0, 2'd3, DB, 1);
        tick();
        set_req(0, 0, 0, 1, 2'd3, 32'h0);
        set_req(1, 1, 0, 0, 2'd0, 32'h0);
        tick();
        set_req(0, 0, 0, 0, 2'd0, 32'h0);
        tick();
        exp_gnt(1, 0, 2'd0, M0, 1);
        tick();
        clear_all();
        tick();

        // Reset in the cycle after a read grant: the return is dropped.
        set_req(0, 1, 0, 0, 2'd1, 32'h0);
        set_req(1, 1, 0, 0, 2'd0, 32'h0);
        exp_gnt(0, 0, 2'd1, M1, 0);
        tick();
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        tick();
        tick();
        clear_all();
        rst_n = 1'b1;
        repeat (4) tick();

        chk("gnt_queue_empty", 64'(gq.size()), 64'h0);
        chk("rd_queue_empty", 64'(rq.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
